// File: rtl/wisc_pkg.sv
// Shared WISC definitions: the NOP encoding, PC reset/increment constants and the fetch FSM states.
package wisc_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_INC    = 16'd2;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    DROP,
    HALTED,
    ERROR
  } fetchState_e;

  // Sequential PC; the 16-bit result wraps 0xFFFE -> 0x0000.
  function automatic logic [15:0] pcIncr(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the I-side memory (slave).
interface fetch_stage_if;

  logic [15:0] memAddr;
  logic        memRd;
  logic [15:0] memData;
  logic        memDone;
  logic        memErr;

  modport master (
    output memAddr, memRd,
    input  memData, memDone, memErr
  );

  modport slave (
    input  memAddr, memRd,
    output memData, memDone, memErr
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry buffer parking an instruction that returned while decode was stalled.
// Instantiated by fetch_stage only when FETCH_SKID_EN is defined.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic        unload,
  input  logic [15:0] loadInstr,
  input  logic [15:0] loadNextPc,
  output logic        full,
  output logic [15:0] instr,
  output logic [15:0] nextPc
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  // NOTE: the payload is not reset; 'full' qualifies it, so a reset term would only add fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      instr  <= loadInstr;
      nextPc <= loadNextPc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding I-memory read at a time, feeding the IF/ID register.
// Build option FETCH_SKID_EN adds a one-entry skid buffer so one fetch proceeds under stall.
module fetch_stage
  import wisc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirectPc,
  input  logic                 haltIn,
  fetch_stage_if.master        mem,
  output logic [15:0]          instrOut,
  output logic [15:0]          nextPcOut,
  output logic                 valid,
  output logic                 err
);

  fetchState_e state, stateNext;
  logic [15:0] pc, pcNext, pcPlus2;
  logic [15:0] instrNext, nextPcNext;
  logic        validNext, errNext;
  logic        haltPend, haltPendNext;
  logic        issue, forceNop;

  assign pcPlus2     = pcIncr(pc);
  assign mem.memAddr = pc;
  // rst is synchronous, so gate the combinational request to keep the bus quiet during reset.
  assign mem.memRd   = issue & ~rst;

`ifdef FETCH_SKID_EN
  logic        skidLoad, skidClear, skidUnload, skidFull;
  logic [15:0] skidInstr, skidNextPc;

  fetch_skid_buf uSkid (
    .clk        (clk),
    .rst        (rst),
    .load       (skidLoad),
    .clear      (skidClear),
    .unload     (skidUnload),
    .loadInstr  (mem.memData),
    .loadNextPc (pcPlus2),
    .full       (skidFull),
    .instr      (skidInstr),
    .nextPc     (skidNextPc)
  );
`endif

  always_comb begin
    // NOTE: every value written here gets a default first; a path that skipped one would infer a latch.
    stateNext    = state;
    pcNext       = pc;
    instrNext    = instrOut;
    nextPcNext   = nextPcOut;
    validNext    = valid;
    errNext      = err;
    haltPendNext = haltPend;
    issue        = 1'b0;
    forceNop     = 1'b0;
`ifdef FETCH_SKID_EN
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    skidUnload   = 1'b0;
`endif

    // An edge that delivers nothing drains IF/ID to a bubble unless decode is holding it.
    if (!stall) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end

    unique case (state)
      ISSUE: begin
        if (redirect) begin
          pcNext   = redirectPc;
          forceNop = 1'b1;
`ifdef FETCH_SKID_EN
          skidClear = 1'b1;
`endif
        end else if (haltIn) begin
          stateNext = HALTED;
          forceNop  = 1'b1;
`ifdef FETCH_SKID_EN
          skidClear = 1'b1;
`endif
        end
`ifdef FETCH_SKID_EN
        else if (skidFull) begin
          if (!stall) begin
            instrNext  = skidInstr;
            nextPcNext = skidNextPc;
            validNext  = 1'b1;
            pcNext     = skidNextPc;
            skidUnload = 1'b1;
          end
        end else begin
          issue     = 1'b1;
          stateNext = WAIT;
        end
`else
        else if (!stall) begin
          issue     = 1'b1;
          stateNext = WAIT;
        end
`endif
      end

      WAIT: begin
        if (redirect) begin
          pcNext    = redirectPc;
          forceNop  = 1'b1;
          stateNext = mem.memDone ? ISSUE : DROP;
        end else if (mem.memDone) begin
          stateNext = ISSUE;
          if (haltIn) begin
            // The word behind a HALT is dead, so its data and any fault are dropped.
            stateNext = HALTED;
            forceNop  = 1'b1;
          end else if (mem.memErr) begin
            stateNext = ERROR;
            errNext   = 1'b1;
            forceNop  = 1'b1;
          end else if (stall) begin
`ifdef FETCH_SKID_EN
            skidLoad = 1'b1;
`endif
            // Without the skid buffer PC stays put and the same word is refetched after the stall.
          end else begin
            instrNext  = mem.memData;
            nextPcNext = pcPlus2;
            validNext  = 1'b1;
            pcNext     = pcPlus2;
          end
        end else if (haltIn) begin
          stateNext    = DROP;
          haltPendNext = 1'b1;
        end
      end

      DROP: begin
        if (redirect) begin
          pcNext       = redirectPc;
          forceNop     = 1'b1;
          haltPendNext = 1'b0;
          if (mem.memDone) stateNext = ISSUE;
        end else if (mem.memDone) begin
          haltPendNext = 1'b0;
          if (haltPend) begin
            stateNext = HALTED;
            forceNop  = 1'b1;
          end else begin
            stateNext = ISSUE;
          end
        end else if (haltIn) begin
          haltPendNext = 1'b1;
        end
      end

      HALTED, ERROR: forceNop = 1'b1;

      default: stateNext = ISSUE;
    endcase

    if (forceNop) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ISSUE;
      pc        <= RESET_PC;
      instrOut  <= NOP_INSTR;
      nextPcOut <= RESET_PC;
      valid     <= 1'b0;
      err       <= 1'b0;
      haltPend  <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      instrOut  <= instrNext;
      nextPcOut <= nextPcNext;
      valid     <= validNext;
      err       <= errNext;
      haltPend  <= haltPendNext;
    end
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001: clk  in  1  pipeline clock; all state updates on rising edge.
- REQ-002: rst  in  1  reset, synchronous, active-high.
- REQ-003: stall  in  1  hazard hold; IF/ID outputs and PC frozen.
- REQ-004: redirect  in  1  taken branch/jump/return resolved downstream; flush.
- REQ-005: redirectPc  in  16  target PC, valid when redirect=1.
- REQ-006: haltIn  in  1  decode has a HALT; stop fetching.
- REQ-007: memAddr  out  16  instruction memory address.
- REQ-008: memRd  out  1  read request, one-cycle pulse per request.
- REQ-009: memData  in  16  returned instruction, valid when memDone=1.
- REQ-010: memDone  in  1  request complete, latency at least 1 cycle after memRd.
- REQ-011: memErr  in  1  memory fault, sampled with memDone.
- REQ-012: instrOut  out  16  instruction to decode, registered.
- REQ-013: nextPcOut  out  16  PC+2 of instrOut, registered.
- REQ-014: valid  out  1  instrOut is a real fetched instruction.
- REQ-015: err  out  1  sticky fetch error.

Function
- REQ-016: States SHALL be ISSUE, WAIT, DROP, HALTED and ERROR; reset enters ISSUE.
- REQ-017: In ISSUE with stall=0, the block SHALL pulse memRd with memAddr=PC and move to WAIT.
- REQ-018: In WAIT on memDone with memErr=0, the block SHALL load instrOut=memData, nextPcOut=PC+2 and valid=1 at that edge, set PC=PC+2 (16-bit wrap, 0xFFFE->0x0000) and return to ISSUE.
- REQ-019: While no instruction is delivered, outputs SHALL be instrOut=16'h0800 (NOP), valid=0; nextPcOut holds.
- REQ-020: stall=1 and redirect=0 SHALL hold instrOut/nextPcOut/valid/PC unchanged; with FETCH_SKID_EN undefined, no new memRd is issued while stall=1.
- REQ-021: redirect SHALL win over stall and haltIn: PC=redirectPc and outputs become NOP/valid=0 at the next edge.
- REQ-022: A redirect in WAIT SHALL enter DROP; the in-flight memDone is discarded; ISSUE resumes at redirectPc.
- REQ-023: memDone and redirect in the same cycle SHALL discard memData and go to ISSUE at redirectPc.
- REQ-024: haltIn=1 without redirect SHALL enter HALTED (after draining any in-flight request); memRd=0 and outputs NOP until rst.
- REQ-025: memErr=1 with memDone SHALL enter ERROR; err=1 sticky, memRd=0, outputs NOP until rst.

Reset
- REQ-026: On rst the block SHALL set PC=0, instrOut=16'h0800, nextPcOut=0, valid=0, err=0, memRd=0, skid buffer empty and state ISSUE; rst mid-WAIT abandons the request, and a later memDone is ignored until the first new memRd.

Configuration
- REQ-027: With FETCH_SKID_EN defined, one request SHALL be issued during stall, and its returned instruction parked in a one-entry skid buffer, delivered at the first edge with stall=0 (zero extra latency) and cleared by redirect.
- REQ-028: With FETCH_SKID_EN undefined, no skid buffer SHALL exist; behaviour follows REQ-020.

Structure
- REQ-029: Shared package wisc_pkg SHALL hold the NOP encoding (16'h0800), the PC increment (2), the reset PC (0) and the fetch state enum.
- REQ-030: The skid buffer SHALL be sub-module fetch_skid_buf, instantiated only under FETCH_SKID_EN.

Verification
- REQ-031: Reset, then memory with 1-cycle latency returning 0x1111 at 0x0000 -> memAddr 0x0000, then 0x0002; instrOut=0x1111, nextPcOut=0x0002, valid=1.
- REQ-032: stall held for 3 cycles after a delivery -> outputs and PC constant, memRd=0 (skid off); skid on: one memRd, instruction delivered at the edge stall falls.
- REQ-033: redirect to 0x0040 during a 3-cycle WAIT -> stale memData never appears; next memAddr=0x0040; valid=0 in between.
- REQ-034: haltIn with redirect in the same cycle -> no halt, fetch resumes at redirectPc; haltIn alone -> memRd stays 0 for 10 cycles.
- REQ-035: memErr on memDone -> err=1 sticky, instrOut=0x0800; rst clears err and restarts at 0x0000.
- REQ-036: PC=0xFFFE delivery -> nextPcOut=0x0000, next memAddr=0x0000.
